// File: rtl/fp_fma_result_buffer_if.sv
// fp_fma_result_buffer_if: issue/result/consumer handshake bundle for the FMA result buffer
//   Issue_i      upstream issues one operation into the FMA stage
//   IssueAllow_o upstream may issue next cycle without risking result loss
//   Valid_i      FMA result present (no backpressure)
//   Res_i        FMA result word
//   Status_i     FMA status for Res_i
//   Valid_o      head entry valid
//   Ready_i      consumer accepts head entry
//   Res_o        head entry result
//   Status_o     head entry status
// Suffixes are from the buffer's point of view; master is the surrounding pipeline, slave the buffer.
interface fp_fma_result_buffer_if #(
    parameter int STAT_WIDTH = 5
);
    logic                  Issue_i;
    logic                  IssueAllow_o;
    logic                  Valid_i;
    logic [31:0]           Res_i;
    logic [STAT_WIDTH-1:0] Status_i;
    logic                  Valid_o;
    logic                  Ready_i;
    logic [31:0]           Res_o;
    logic [STAT_WIDTH-1:0] Status_o;

    modport master (
        output Issue_i, Valid_i, Res_i, Status_i, Ready_i,
        input  IssueAllow_o, Valid_o, Res_o, Status_o
    );

    modport slave (
        input  Issue_i, Valid_i, Res_i, Status_i, Ready_i,
        output IssueAllow_o, Valid_o, Res_o, Status_o
    );
endinterface

// File: rtl/fp_fma_result_buffer.sv
// fp_fma_result_buffer: first-word fall-through FIFO catching FMA results, with in-flight credit accounting
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   bus         fp_fma_result_buffer_if.slave (issue, result push, head pop handshakes)
//   FlagsClr_i  clears the sticky exception flags
//   Ovf_o       sticky overflow error (dropped result or in-flight counter saturation)
//   Flags_o     sticky OR of pushed status words
// Optional feature: define FP_RESBUF_STICKY_FLAGS_EN to build the sticky flag register;
// otherwise Flags_o is tied to 0 and FlagsClr_i is ignored.
module fp_fma_result_buffer #(
    parameter int DEPTH      = 4,
    parameter int STAT_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    fp_fma_result_buffer_if.slave bus,
    input  logic                  FlagsClr_i,
    output logic                  Ovf_o,
    output logic [STAT_WIDTH-1:0] Flags_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]           res_q  [DEPTH];
    logic [STAT_WIDTH-1:0] stat_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d, inflt_q, inflt_d;
    logic [CW:0]           occ_sum;
    logic                  ovf_q, ovf_d;
    logic                  full, push, pop, inc, dec, inflt_err;

    always_comb begin
        full         = cnt_q == FULL;
        bus.Valid_o  = cnt_q != '0;
        bus.Res_o    = res_q[rptr_q];
        bus.Status_o = stat_q[rptr_q];
        pop          = bus.Valid_o && bus.Ready_i;
        push         = bus.Valid_i && (!full || pop);
        wptr_d       = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d       = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d        = cnt_q + CW'(push) - CW'(pop);
        // An issue and a returning result in the same cycle cancel out
        inc          = bus.Issue_i && !bus.Valid_i;
        dec          = bus.Valid_i && !bus.Issue_i;
        inflt_err    = (inc && inflt_q == FULL) || (dec && inflt_q == '0);
        inflt_d      = inflt_err ? inflt_q : inc ? inflt_q + 1'b1 : dec ? inflt_q - 1'b1 : inflt_q;
        ovf_d        = ovf_q || inflt_err || (bus.Valid_i && !push);
        // Registered occupancy only, so a pop this cycle frees credit next cycle
        occ_sum      = {1'b0, cnt_q} + {1'b0, inflt_q};
        bus.IssueAllow_o = occ_sum < {1'b0, FULL};
        Ovf_o        = ovf_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            inflt_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            inflt_q <= inflt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is not reset; contents are only observed while Valid_o is high
    always_ff @(posedge clk_i) begin
        if (push) begin
            res_q[wptr_q]  <= bus.Res_i;
            stat_q[wptr_q] <= bus.Status_i;
        end
    end

`ifdef FP_RESBUF_STICKY_FLAGS_EN
    logic [STAT_WIDTH-1:0] flags_q, flags_d, flags_base;

    // Clear wins over history but not over a same-cycle push
    always_comb begin
        flags_base = FlagsClr_i ? '0 : flags_q;
        flags_d    = push ? flags_base | bus.Status_i : flags_base;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) flags_q <= '0;
        else         flags_q <= flags_d;
    end

    assign Flags_o = flags_q;
`else
    logic unused_flags_clr;

    assign unused_flags_clr = FlagsClr_i;
    assign Flags_o          = '0;
`endif
endmodule

// File: tb/tb_fp_fma_result_buffer.sv
// tb_fp_fma_result_buffer: directed self-checking bench for fp_fma_result_buffer
module tb_fp_fma_result_buffer;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flags_clr;
    logic       ovf;
    logic [4:0] flags;
    int         checks = 0;
    int         errors = 0;

    fp_fma_result_buffer_if #(.STAT_WIDTH(5)) bus ();

    fp_fma_result_buffer #(.DEPTH(4), .STAT_WIDTH(5)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bus        (bus),
        .FlagsClr_i (flags_clr),
        .Ovf_o      (ovf),
        .Flags_o    (flags)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic iss, input logic vld, input logic [31:0] r, input logic [4:0] s, input logic rdy);
        bus.Issue_i  = iss;
        bus.Valid_i  = vld;
        bus.Res_i    = r;
        bus.Status_i = s;
        bus.Ready_i  = rdy;
        @(posedge clk_i);
        #1;
        bus.Issue_i  = 1'b0;
        bus.Valid_i  = 1'b0;
        bus.Ready_i  = 1'b0;
        flags_clr    = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        chk("rst_valid", bus.Valid_o, 0);
        chk("rst_allow", bus.IssueAllow_o, 1);
        chk("rst_ovf", ovf, 0);
        chk("rst_flags", flags, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni       = 1'b1;
        flags_clr    = 1'b0;
        bus.Issue_i  = 1'b0;
        bus.Valid_i  = 1'b0;
        bus.Res_i    = '0;
        bus.Status_i = '0;
        bus.Ready_i  = 1'b0;
        #1;
        do_reset();

        // single operation round trip
        cyc(1, 0, 0, 0, 0);
        chk("t1_allow_issue", bus.IssueAllow_o, 1);
        cyc(0, 0, 0, 0, 0);
        bus.Valid_i = 1'b1;
        bus.Res_i   = 32'h3F800000;
        #1;
        chk("t1_no_bypass", bus.Valid_o, 0);
        cyc(0, 1, 32'h3F800000, 0, 1);
        chk("t1_valid", bus.Valid_o, 1);
        chk("t1_res", bus.Res_o, 32'h3F800000);
        chk("t1_allow", bus.IssueAllow_o, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t1_empty", bus.Valid_o, 0);
        chk("t1_ovf", ovf, 0);

        // four issues exhaust the credit, four results fill the FIFO
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0);
            chk($sformatf("t2_allow%0d", i), bus.IssueAllow_o, (i < 3) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 32'h10000000 + i, 5'(i), 0);
            chk($sformatf("t2_allow_res%0d", i), bus.IssueAllow_o, 0);
        end
        chk("t2_valid", bus.Valid_o, 1);
        chk("t2_head", bus.Res_o, 32'h10000000);
        chk("t2_ovf", ovf, 0);

        // full FIFO: push and pop in the same cycle
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'h10000004, 5'd4, 1);
        chk("t3_ovf", ovf, 0);
        chk("t3_allow", bus.IssueAllow_o, 0);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("t3_res%0d", i), bus.Res_o, 32'h10000000 + i);
            chk($sformatf("t3_stat%0d", i), bus.Status_o, i);
            cyc(0, 0, 0, 0, 1);
        end
        chk("t3_empty", bus.Valid_o, 0);
        chk("t3_allow_empty", bus.IssueAllow_o, 1);

        // full FIFO with no pop drops the incoming result
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'h20000000 + i, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hDEADBEEF, 0, 0);
        chk("t4_ovf", ovf, 1);
        chk("t4_head", bus.Res_o, 32'h20000000);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_res%0d", i), bus.Res_o, 32'h20000000 + i);
            cyc(0, 0, 0, 0, 1);
        end
        chk("t4_empty", bus.Valid_o, 0);
        chk("t4_ovf_sticky", ovf, 1);
        do_reset();

`ifdef FP_RESBUF_STICKY_FLAGS_EN
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'h1, 5'b00100, 1);
        cyc(0, 1, 32'h2, 5'b00010, 1);
        chk("t5_flags_or", flags, 5'b00110);
        flags_clr = 1'b1;
        cyc(0, 1, 32'h3, 5'b00001, 1);
        chk("t5_flags_clr_push", flags, 5'b00001);
        flags_clr = 1'b1;
        cyc(0, 0, 0, 0, 1);
        chk("t5_flags_clr", flags, 0);
`else
        cyc(1, 0, 0, 0, 0);
        flags_clr = 1'b1;
        cyc(0, 1, 32'h1, 5'b11111, 1);
        chk("t5_flags_off", flags, 0);
`endif
        chk("t5_ovf", ovf, 0);
        do_reset();

        // reset with 3 stored and 1 in flight
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h30000000 + i, 0, 0);
        chk("t6_allow_pre", bus.IssueAllow_o, 0);
        chk("t6_valid_pre", bus.Valid_o, 1);
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'h40000000, 0, 0);
        chk("t6_ovf_reissued", ovf, 0);
        chk("t6_head", bus.Res_o, 32'h40000000);
        cyc(0, 1, 32'h40000001, 0, 0);
        chk("t6_ovf_underflow", ovf, 1);
        do_reset();

        // in-flight counter saturates at DEPTH
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        chk("t7_ovf_at_depth", ovf, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t7_ovf_sat", ovf, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
